// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : issue_scheduler
//  Description : Select-and-issue controller for the out-of-order issue
//                queue. Picks at most one ready entry per issue port with a
//                per-port round-robin pointer, registers the pick into a
//                per-port issue slot (valid/ready handshake towards the FU)
//                and returns a one-cycle clear pulse per granted entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
  parameter int IQ_SIZE     = 64,
  parameter int ISSUE_PORTS = 3,
  parameter int IDX_W       = $clog2(IQ_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_in,
  input  logic                         flush,
  input  logic [IQ_SIZE-1:0]           req_valid,
  input  logic [2*IQ_SIZE-1:0]         req_class,
  input  logic [ISSUE_PORTS-1:0]       fu_ready,
  output logic [ISSUE_PORTS-1:0]       iss_valid,
  output logic [ISSUE_PORTS*IDX_W-1:0] iss_idx,
  output logic [IQ_SIZE-1:0]           issue_clr
);

  localparam logic [IQ_SIZE-1:0] c_one_hot_base = IQ_SIZE'(1);

  // Registered state: issue slots, clear pulses and round-robin pointers.
  logic [ISSUE_PORTS-1:0]            r_iss_valid;
  logic [ISSUE_PORTS-1:0][IDX_W-1:0] r_iss_idx;
  logic [IQ_SIZE-1:0]                r_issue_clr;
  logic [ISSUE_PORTS-1:0][IDX_W-1:0] r_rr;

  // Per-port combinational decisions gathered into packed vectors so a
  // single sequential process can update every slot.
  logic [ISSUE_PORTS-1:0]              w_grant;
  logic [ISSUE_PORTS-1:0]              w_xfer;
  logic [ISSUE_PORTS-1:0]              w_load_ok;
  logic [ISSUE_PORTS-1:0][IDX_W-1:0]   w_pick;
  logic [ISSUE_PORTS-1:0][IQ_SIZE-1:0] w_clr_by_port;
  logic [IQ_SIZE-1:0]                  w_clr_next;

  genvar gp;
  generate
    for (gp = 0; gp < ISSUE_PORTS; gp++) begin : g_port
      // Port gp serves FU class gp; the class field is two bits wide, so a
      // class value at or above ISSUE_PORTS simply never matches any port.
      localparam logic [1:0] c_cls = 2'(gp);

      logic [IQ_SIZE-1:0] w_cand;
      logic [IDX_W-1:0]   w_probe;
      logic [IDX_W-1:0]   w_sel;
      logic               w_any;

      // Candidate set: ready entries of this port's class that are not
      // already being cleared (the IQ has not dropped them yet).
      always_comb begin
        w_cand = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
          w_cand[i] = req_valid[i] && (req_class[2*i +: 2] == c_cls) && !r_issue_clr[i];
        end
      end

      // Round-robin pick: scan from the pointer upward with natural
      // modulo-IQ_SIZE wrap; iterating high-to-low lets the lowest offset win.
      always_comb begin
        w_any   = 1'b0;
        w_sel   = r_rr[gp];
        w_probe = '0;
        for (int j = IQ_SIZE - 1; j >= 0; j--) begin
          w_probe = r_rr[gp] + IDX_W'(j);
          if (w_cand[w_probe]) begin
            w_any = 1'b1;
            w_sel = w_probe;
          end
        end
      end

      assign w_load_ok[gp]     = !r_iss_valid[gp] || fu_ready[gp];
      assign w_xfer[gp]        = r_iss_valid[gp] && fu_ready[gp];
      assign w_grant[gp]       = w_load_ok[gp] && !stall_in && !flush && w_any;
      assign w_pick[gp]        = w_sel;
      assign w_clr_by_port[gp] = w_grant[gp] ? (c_one_hot_base << w_sel) : '0;
    end
  endgenerate

  // Merge per-port clear requests; classes are disjoint so bits never collide.
  always_comb begin
    w_clr_next = '0;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      w_clr_next = w_clr_next | w_clr_by_port[p];
    end
  end

  // Slot load, drain and pointer advance all happen at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_valid <= '0;
      r_iss_idx   <= '0;
      r_issue_clr <= '0;
      r_rr        <= '0;
    end else begin
      // Grants are already suppressed by flush/stall, so this is zero then.
      r_issue_clr <= w_clr_next;
      for (int p = 0; p < ISSUE_PORTS; p++) begin
        if (flush) begin
          r_iss_valid[p] <= 1'b0;
        end else if (w_grant[p]) begin
          r_iss_valid[p] <= 1'b1;
          r_iss_idx[p]   <= w_pick[p];
          r_rr[p]        <= w_pick[p] + IDX_W'(1);
        end else if (w_xfer[p]) begin
          r_iss_valid[p] <= 1'b0;
        end
      end
    end
  end

  assign iss_valid = r_iss_valid;
  assign iss_idx   = r_iss_idx;
  assign issue_clr = r_issue_clr;

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_scheduler
//  Description : Self-checking bench for issue_scheduler. Each scenario task
//                drives the IQ-side inputs, pushes the expected slot/clear
//                state onto a scoreboard queue and pops/compares it one
//                cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

  localparam int IQ = 64;
  localparam int NP = 3;
  localparam int IW = 6;

  typedef struct packed {
    logic [NP-1:0]    v;
    logic [NP*IW-1:0] idx;
    logic [NP*IW-1:0] imask;
    logic [IQ-1:0]    clr;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall_in;
  logic             flush;
  logic [IQ-1:0]    req_valid;
  logic [2*IQ-1:0]  req_class;
  logic [NP-1:0]    fu_ready;
  logic [NP-1:0]    iss_valid;
  logic [NP*IW-1:0] iss_idx;
  logic [IQ-1:0]    issue_clr;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  issue_scheduler #(.IQ_SIZE(IQ), .ISSUE_PORTS(NP), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_in  (stall_in),
    .flush     (flush),
    .req_valid (req_valid),
    .req_class (req_class),
    .fu_ready  (fu_ready),
    .iss_valid (iss_valid),
    .iss_idx   (iss_idx),
    .issue_clr (issue_clr)
  );

  always #5 clk = ~clk;

  // Expected state builder; slot indices are only checked where the slot is
  // expected valid, unless all_idx asks for every index (reset cases).
  function automatic exp_t mk(input logic [NP-1:0] v, input int i0, input int i1,
                              input int i2, input logic [IQ-1:0] clr, input bit all_idx);
    exp_t r;
    r.v   = v;
    r.idx = {IW'(i2), IW'(i1), IW'(i0)};
    for (int p = 0; p < NP; p++) r.imask[p*IW +: IW] = (v[p] || all_idx) ? '1 : '0;
    r.clr = clr;
    return r;
  endfunction

  function automatic logic [IQ-1:0] bit_at(input int k);
    logic [IQ-1:0] one;
    one = 1;
    return one << k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_class = '0;
  endtask

  task automatic set_entry(input int i, input int cls);
    req_valid[i]        = 1'b1;
    req_class[2*i +: 2] = 2'(cls);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    for (int s = 0; s < 12; s++) begin
      if (s == 2) rst = 1'b0;
      sb.push_back(mk('0, 0, 0, 0, '0, 1'b1));
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL reset step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    clear_req();
    fu_ready = '1;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin set_entry(5, 1); sb.push_back(mk(3'b010, 0, 5, 0, bit_at(5), 1'b0)); end
        1: sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
        default: begin clear_req(); sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0)); end
      endcase
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL single step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   seq[4] = '{2, 9, 40, 2};
    int   wrp[3] = '{62, 63, 1};
    clear_req();
    fu_ready = '1;
    for (int s = 0; s < 9; s++) begin
      if (s < 4) begin
        clear_req(); set_entry(2, 0); set_entry(9, 0); set_entry(40, 0);
        sb.push_back(mk(3'b001, seq[s], 0, 0, bit_at(seq[s]), 1'b0));
      end else if (s == 4 || s == 8) begin
        clear_req();
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end else begin
        clear_req();
        if (s == 5) set_entry(62, 0);
        else begin set_entry(63, 0); set_entry(1, 0); end
        sb.push_back(mk(3'b001, wrp[s-5], 0, 0, bit_at(wrp[s-5]), 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL round_robin step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    for (int s = 0; s < 7; s++) begin
      clear_req();
      if (s == 0) begin
        set_entry(7, 2); set_entry(8, 2); fu_ready = 3'b011;
        sb.push_back(mk(3'b100, 0, 0, 7, bit_at(7), 1'b0));
      end else if (s <= 4) begin
        set_entry(8, 2); fu_ready = 3'b011;
        sb.push_back(mk(3'b100, 0, 0, 7, '0, 1'b0));
      end else if (s == 5) begin
        set_entry(8, 2); fu_ready = 3'b111;
        sb.push_back(mk(3'b100, 0, 0, 8, bit_at(8), 1'b0));
      end else begin
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL backpressure step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
  endtask

  task automatic test_parallel();
    exp_t e;
    fu_ready = '1;
    for (int s = 0; s < 4; s++) begin
      clear_req();
      set_entry(3, 3);
      if (s < 2) begin set_entry(0, 0); set_entry(1, 1); set_entry(2, 2); end
      if (s == 0) sb.push_back(mk(3'b111, 0, 1, 2, IQ'(7), 1'b0));
      else        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL parallel step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    fu_ready = '1;
    for (int s = 0; s < 6; s++) begin
      clear_req();
      stall_in = (s >= 1 && s <= 3);
      if (s == 0) begin
        set_entry(4, 0);
        sb.push_back(mk(3'b001, 4, 0, 0, bit_at(4), 1'b0));
      end else if (s <= 3) begin
        set_entry(10, 0);
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end else if (s == 4) begin
        set_entry(10, 0);
        sb.push_back(mk(3'b001, 10, 0, 0, bit_at(10), 1'b0));
      end else begin
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL stall step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
    stall_in = 1'b0;
  endtask

  task automatic test_flush();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      clear_req();
      flush = (s == 1);
      if (s == 0) begin
        set_entry(20, 0); set_entry(21, 1); set_entry(22, 2); fu_ready = 3'b000;
        sb.push_back(mk(3'b111, 20, 21, 22, bit_at(20) | bit_at(21) | bit_at(22), 1'b0));
      end else if (s == 1) begin
        set_entry(19, 0); set_entry(23, 0); fu_ready = 3'b000;
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end else if (s == 2) begin
        // Pointer 0 must still sit just past 20, so 23 wins over 19.
        set_entry(19, 0); set_entry(23, 0); fu_ready = 3'b111;
        sb.push_back(mk(3'b001, 23, 0, 0, bit_at(23), 1'b0));
      end else begin
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL flush step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   p0[4] = '{30, 31, 30, 31};
    int   p1[4] = '{32, 33, 32, 33};
    int   p2[4] = '{34, 35, 34, 35};
    fu_ready = '1;
    for (int s = 0; s < 5; s++) begin
      clear_req();
      if (s < 4) begin
        set_entry(30, 0); set_entry(31, 0); set_entry(32, 1);
        set_entry(33, 1); set_entry(34, 2); set_entry(35, 2);
        sb.push_back(mk(3'b111, p0[s], p1[s], p2[s],
                        bit_at(p0[s]) | bit_at(p1[s]) | bit_at(p2[s]), 1'b0));
      end else begin
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL back_to_back step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      clear_req();
      rst = (s == 1);
      if (s == 0) begin
        set_entry(40, 1); set_entry(50, 1); fu_ready = 3'b000;
        sb.push_back(mk(3'b010, 0, 40, 0, bit_at(40), 1'b0));
      end else if (s == 1) begin
        set_entry(40, 1); set_entry(50, 1); fu_ready = 3'b000;
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b1));
      end else if (s == 2) begin
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b1));
      end else if (s == 3) begin
        // Pointer 1 is back at 0 after reset, so 40 wins over 50 again.
        set_entry(50, 1); set_entry(40, 1); fu_ready = 3'b111;
        sb.push_back(mk(3'b010, 0, 40, 0, bit_at(40), 1'b0));
      end else begin
        sb.push_back(mk(3'b000, 0, 0, 0, '0, 1'b0));
      end
      tick();
      e = sb.pop_front();
      n_vec++;
      if (iss_valid !== e.v || ((iss_idx ^ e.idx) & e.imask) !== '0 || issue_clr !== e.clr) begin
        n_err++;
        $display("FAIL reset_mid step %0d: got valid=%b idx=%h clr=%h, want valid=%b idx=%h clr=%h",
                 s, iss_valid, iss_idx, issue_clr, e.v, e.idx & e.imask, e.clr);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    stall_in  = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    req_class = '0;
    fu_ready  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_parallel();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
